// File: rtl/sram_lane_clr.sv
// Single-clock SRAM: one write port with per-lane enables, one registered read
// port with write-first forwarding. A sequencer fills every word with CLR_VAL after reset or on request.
module sram_lane_clr #(
   parameter int A = 7,
   parameter int W = 16,
   parameter int L = 2,
   parameter logic [W-1:0] CLR_VAL = '0
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         clear,
   input  logic         write,
   input  logic [A-1:0] wrAddress,
   input  logic [W-1:0] dataInput,
   input  logic [L-1:0] laneEnable,
   input  logic         read,
   input  logic [A-1:0] rdAddress,
   output logic [W-1:0] dataOutput,
   output logic         dataValid,
   output logic         ready
);

   localparam int LW    = W / L;
   localparam int DEPTH = 2 ** A;

   typedef enum logic {S_CLEAR, S_READY} state_t;

   state_t         state_reg, state_next;
   logic [A-1:0]   cnt_reg, cnt_next;
   logic           clearing;
   logic           accept_wr;
   logic           accept_rd;
   logic [W-1:0]   rd_word;

   assign ready     = (state_reg == S_READY);
   // The array is left untouched while RST is held; the fill starts after release.
   assign clearing  = (state_reg == S_CLEAR) && !RST;
   assign accept_wr = ready && !clear && write;
   assign accept_rd = ready && !clear && read;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_reg <= S_CLEAR;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         S_CLEAR: begin
            if (cnt_reg == {A{1'b1}}) begin
               state_next = S_READY;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         S_READY: begin
            if (clear) begin
               state_next = S_CLEAR;
               cnt_next   = '0;
            end
         end
         default: begin
            state_next = S_CLEAR;
            cnt_next   = '0;
         end
      endcase
   end

   // One storage array per lane so each lane has its own write enable.
   genvar gi;
   generate
      for (gi = 0; gi < L; gi++) begin : g_lane
         logic [LW-1:0] mem [DEPTH];
         logic          lane_we;
         logic [A-1:0]  lane_addr;
         logic [LW-1:0] lane_wdata;
         logic          lane_fwd;

         assign lane_we    = clearing || (accept_wr && laneEnable[gi]);
         assign lane_addr  = clearing ? cnt_reg : wrAddress;
         assign lane_wdata = clearing ? CLR_VAL[gi*LW +: LW] : dataInput[gi*LW +: LW];
         assign lane_fwd   = accept_wr && laneEnable[gi] && (wrAddress == rdAddress);

         always_ff @(posedge CLK) begin
            if (lane_we) begin
               mem[lane_addr] <= lane_wdata;
            end
         end

         assign rd_word[gi*LW +: LW] = lane_fwd ? dataInput[gi*LW +: LW] : mem[rdAddress];
      end
   endgenerate

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         dataOutput <= '0;
         dataValid  <= 1'b0;
      end else begin
         dataValid <= accept_rd;
         if (accept_rd) begin
            dataOutput <= rd_word;
         end
      end
   end

endmodule

// File: tb/tb_sram_lane_clr.sv
// Directed bench for sram_lane_clr with A=4, W=16, L=2, CLR_VAL=16'hA5A5:
// a vector table for READY-state traffic plus sequences for clear and reset timing.
module tb_sram_lane_clr;

   localparam int A = 4;
   localparam int W = 16;
   localparam int L = 2;
   localparam logic [W-1:0] CV = 16'hA5A5;

   logic         CLK = 1'b0;
   logic         RST = 1'b1;
   logic         clear = 1'b0;
   logic         write = 1'b0;
   logic [A-1:0] wrAddress = '0;
   logic [W-1:0] dataInput = '0;
   logic [L-1:0] laneEnable = '0;
   logic         read = 1'b0;
   logic [A-1:0] rdAddress = '0;
   logic [W-1:0] dataOutput;
   logic         dataValid;
   logic         ready;

   int checks = 0;
   int failures = 0;

   sram_lane_clr #(.A(A), .W(W), .L(L), .CLR_VAL(CV)) dut (
      .CLK(CLK), .RST(RST), .clear(clear), .write(write), .wrAddress(wrAddress),
      .dataInput(dataInput), .laneEnable(laneEnable), .read(read), .rdAddress(rdAddress),
      .dataOutput(dataOutput), .dataValid(dataValid), .ready(ready)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic         wr;
      logic [A-1:0] wa;
      logic [W-1:0] din;
      logic [L-1:0] le;
      logic         rd;
      logic [A-1:0] ra;
      logic         ev;
      logic [W-1:0] ed;
   } vec_t;

   vec_t vecs [12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic idle_inputs();
      clear = 1'b0; write = 1'b0; read = 1'b0; laneEnable = '0;
   endtask

   // Counts edges until ready rises; dataValid must stay low throughout.
   task automatic wait_ready(input string name, input int exp_edges);
      int n = 0;
      while (n < 40 && ready !== 1'b1) begin
         step();
         n++;
         check({name, "_valid_low"}, {31'd0, dataValid}, 32'd0);
      end
      check({name, "_latency"}, n, exp_edges);
   endtask

   task automatic read_all(input string name);
      for (int a = 0; a < 16; a++) begin
         read = 1'b1;
         rdAddress = A'(a);
         step();
         check({name, "_valid"}, {31'd0, dataValid}, 32'd1);
         check({name, "_data"}, {16'd0, dataOutput}, {16'd0, CV});
         $display("read addr=%0d data=%h valid=%0d", a, dataOutput, dataValid);
      end
      read = 1'b0;
   endtask

   initial begin
      // wr  wa     din        le     rd  ra     ev   ed
      vecs[0]  = '{1'b1, 4'd3, 16'h1234, 2'b11, 1'b0, 4'd0, 1'b0, 16'hA5A5};
      vecs[1]  = '{1'b1, 4'd3, 16'hFFFF, 2'b01, 1'b0, 4'd0, 1'b0, 16'hA5A5};
      vecs[2]  = '{1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'd3, 1'b1, 16'h12FF};
      vecs[3]  = '{1'b1, 4'd5, 16'hBEEF, 2'b10, 1'b1, 4'd5, 1'b1, 16'hBEA5};
      vecs[4]  = '{1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'd5, 1'b1, 16'hBEA5};
      vecs[5]  = '{1'b1, 4'd7, 16'h5A5A, 2'b11, 1'b1, 4'd6, 1'b1, 16'hA5A5};
      vecs[6]  = '{1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'd7, 1'b1, 16'h5A5A};
      vecs[7]  = '{1'b0, 4'd0, 16'h0000, 2'b00, 1'b0, 4'd0, 1'b0, 16'h5A5A};
      vecs[8]  = '{1'b1, 4'd8, 16'hC3C3, 2'b01, 1'b1, 4'd8, 1'b1, 16'hA5C3};
      vecs[9]  = '{1'b1, 4'd8, 16'h0F0F, 2'b00, 1'b1, 4'd8, 1'b1, 16'hA5C3};
      vecs[10] = '{1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'd9, 1'b1, 16'hA5A5};
      vecs[11] = '{1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'd3, 1'b1, 16'h12FF};

      // Reset state
      repeat (3) step();
      check("rst_ready", {31'd0, ready}, 32'd0);
      check("rst_valid", {31'd0, dataValid}, 32'd0);
      check("rst_dout", {16'd0, dataOutput}, 32'd0);

      // Release with traffic on addr 0 that must be ignored during the fill
      write = 1'b1; wrAddress = '0; dataInput = 16'h0000; laneEnable = 2'b11;
      read = 1'b1; rdAddress = '0;
      RST = 1'b0;
      wait_ready("init_clear", 16);
      idle_inputs();
      read_all("init_read");

      // READY-state vector table
      for (int i = 0; i < 12; i++) begin
         write = vecs[i].wr; wrAddress = vecs[i].wa; dataInput = vecs[i].din;
         laneEnable = vecs[i].le; read = vecs[i].rd; rdAddress = vecs[i].ra;
         step();
         check($sformatf("vec%0d_valid", i), {31'd0, dataValid}, {31'd0, vecs[i].ev});
         check($sformatf("vec%0d_data", i), {16'd0, dataOutput}, {16'd0, vecs[i].ed});
         $display("vec %0d wr=%0d wa=%0d din=%h le=%b rd=%0d ra=%0d -> valid=%0d data=%h",
                  i, vecs[i].wr, vecs[i].wa, vecs[i].din, vecs[i].le, vecs[i].rd,
                  vecs[i].ra, dataValid, dataOutput);
      end

      // Asynchronous reset in the middle of normal traffic
      idle_inputs();
      #2 RST = 1'b1;
      #1;
      check("midop_rst_valid", {31'd0, dataValid}, 32'd0);
      check("midop_rst_dout", {16'd0, dataOutput}, 32'd0);
      check("midop_rst_ready", {31'd0, ready}, 32'd0);
      @(negedge CLK);
      RST = 1'b0;
      wait_ready("midop_clear", 16);

      // Re-clear with a simultaneous write that must be dropped
      write = 1'b1; wrAddress = 4'd2; dataInput = 16'h2222; laneEnable = 2'b11;
      step();
      idle_inputs();
      read = 1'b1; rdAddress = 4'd2;
      step();
      check("pre_clear_data", {16'd0, dataOutput}, 32'h2222);
      clear = 1'b1; write = 1'b1; wrAddress = 4'd2; dataInput = 16'h1111;
      laneEnable = 2'b11; read = 1'b1; rdAddress = 4'd2;
      step();
      idle_inputs();
      check("reclear_ready_low", {31'd0, ready}, 32'd0);
      check("reclear_valid_low", {31'd0, dataValid}, 32'd0);
      wait_ready("reclear", 16);
      read = 1'b1; rdAddress = 4'd2;
      step();
      read = 1'b0;
      check("reclear_addr2", {16'd0, dataOutput}, {16'd0, CV});
      $display("reclear addr=2 data=%h valid=%0d", dataOutput, dataValid);

      // Reset while the clear counter sits at 7
      write = 1'b1; wrAddress = 4'd15; dataInput = 16'h7777; laneEnable = 2'b11;
      step();
      idle_inputs();
      clear = 1'b1;
      step();
      clear = 1'b0;
      repeat (7) step();
      check("midclr_ready_low", {31'd0, ready}, 32'd0);
      #2 RST = 1'b1;
      #1;
      check("midclr_rst_dout", {16'd0, dataOutput}, 32'd0);
      check("midclr_rst_valid", {31'd0, dataValid}, 32'd0);
      @(negedge CLK);
      RST = 1'b0;
      wait_ready("midclr", 16);
      read_all("midclr_read");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
